// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the intr_ctrl interrupt controller: register offsets,
// FSM state type and a lowest-set-bit helper.
package intr_ctrl_pkg;

    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_MODE    = 3'd2;
    localparam logic [2:0] REG_ID      = 3'd3;
    localparam logic [2:0] REG_EOI     = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } intr_state_e;

    // Index 0 has the highest priority; an all-zero vector returns 0.
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// One interrupt channel front end: SYNC_STAGES-deep synchroniser, a history
// flop, the synchronised level and a one-cycle rising-edge pulse.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of its neighbour; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised, maskable interrupt controller in front of the MCU intr/int_ack pair.
// Define INTR_NEST_EN to allow a higher-priority source to pre-empt one in service.
module intr_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int ID_W        = $clog2(NUM_IRQ),
    parameter int SYNC_STAGES = 2
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               io_cs,
    input  logic               io_rd,
    input  logic               io_wr,
    input  logic [2:0]         io_addr,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    output logic               intr,
    input  logic               int_ack,
    output logic [ID_W-1:0]    irq_id
);
    import intr_ctrl_pkg::*;

    logic [NUM_IRQ-1:0] sync_lvl, sync_rise;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        intr_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (sys_clk),
            .rst_ni (reset),
            .irq_i  (irq_in[g]),
            .level_o(sync_lvl[g]),
            .rise_o (sync_rise[g])
        );
    end

    intr_state_e        state_q, state_d;
    logic               intr_q, intr_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, mode_q;
    logic [31:0]        rdata_q, rdata_d;

    logic               wr_en, rd_en, eoi;
    logic [NUM_IRQ-1:0] pending_eff, req, id_onehot, ack_clr, w1c;
    logic [ID_W-1:0]    winner;
    logic               unused_wdata;

    assign wr_en = io_cs & io_wr;
    assign rd_en = io_cs & io_rd;
    assign eoi   = wr_en && (io_addr == REG_EOI);
    assign w1c   = (wr_en && (io_addr == REG_PENDING)) ? io_wdata[NUM_IRQ-1:0] : '0;
    assign unused_wdata = ^io_wdata;

    // pending_q only holds edge channels; level channels follow the synchronised input.
    assign pending_eff = (mode_q & pending_q) | (~mode_q & sync_lvl);
    assign req         = pending_eff & enable_q;
    assign winner      = ID_W'(lowest_set(32'(req)));
    assign id_onehot   = NUM_IRQ'(1) << irq_id_q;

`ifdef INTR_NEST_EN
    logic [NUM_IRQ-1:0] isr_after_eoi;
    logic [ID_W-1:0]    isr_low, isr_after_low;
    assign isr_after_eoi = isr_q & (isr_q - NUM_IRQ'(1));
    assign isr_low       = ID_W'(lowest_set(32'(isr_q)));
    assign isr_after_low = ID_W'(lowest_set(32'(isr_after_eoi)));
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        intr_d   = intr_q;
        irq_id_d = irq_id_q;
        isr_d    = isr_q;
        ack_clr  = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    irq_id_d = winner;
                    intr_d   = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (int_ack) begin
                    intr_d  = 1'b0;
                    isr_d   = isr_q | id_onehot;
                    ack_clr = id_onehot;
                    state_d = SERVICE;
                end else if (!(|(req & id_onehot))) begin
                    intr_d = 1'b0;
`ifdef INTR_NEST_EN
                    if (|isr_q) begin
                        irq_id_d = isr_low;
                        state_d  = SERVICE;
                    end else begin
                        irq_id_d = '0;
                        state_d  = IDLE;
                    end
`else
                    irq_id_d = '0;
                    state_d  = IDLE;
`endif
                end else if (winner < irq_id_q) begin
                    irq_id_d = winner;
                end
            end
            SERVICE: begin
`ifdef INTR_NEST_EN
                if (eoi) begin
                    isr_d = isr_after_eoi;
                    if (isr_after_eoi == '0) begin
                        irq_id_d = '0;
                        state_d  = IDLE;
                    end else begin
                        irq_id_d = isr_after_low;
                    end
                end else if ((|req) && (winner < isr_low)) begin
                    irq_id_d = winner;
                    intr_d   = 1'b1;
                    state_d  = ASSERT;
                end
`else
                if (eoi) begin
                    isr_d    = '0;
                    irq_id_d = '0;
                    state_d  = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise in the same cycle as a clear wins.
    assign pending_d = mode_q & (sync_rise | (pending_q & ~(w1c | ack_clr)));

    always_comb begin
        rdata_d = '0;
        case (io_addr)
            REG_ENABLE:  rdata_d = 32'(enable_q);
            REG_PENDING: rdata_d = 32'(pending_eff);
            REG_MODE:    rdata_d = 32'(mode_q);
            REG_ID: begin
                rdata_d[31]       = |isr_q;
                rdata_d[ID_W-1:0] = irq_id_q;
            end
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            intr_q    <= 1'b0;
            irq_id_q  <= '0;
            isr_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            irq_id_q  <= irq_id_d;
            isr_q     <= isr_d;
            pending_q <= pending_d;
            if (wr_en && (io_addr == REG_ENABLE)) enable_q <= io_wdata[NUM_IRQ-1:0];
            if (wr_en && (io_addr == REG_MODE))   mode_q   <= io_wdata[NUM_IRQ-1:0];
            if (rd_en)                            rdata_q  <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;
    assign intr     = intr_q;
    assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model of the controller.
module tb_intr_ctrl;

    localparam int N     = 8;
    localparam int ID_W  = 3;
    localparam int SYNC  = 2;

    localparam int M_IDLE = 0, M_ASSERT = 1, M_SERVICE = 2;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic [N-1:0]  irq_in  = '0;
    logic          io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
    logic [2:0]    io_addr  = '0;
    logic [31:0]   io_wdata = '0;
    logic [31:0]   io_rdata;
    logic          intr;
    logic          int_ack = 1'b0;
    logic [ID_W-1:0] irq_id;

    int n_cmp = 0;
    int n_err = 0;

    intr_ctrl #(.NUM_IRQ(N), .ID_W(ID_W), .SYNC_STAGES(SYNC)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .io_cs   (io_cs),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .intr    (intr),
        .int_ack (int_ack),
        .irq_id  (irq_id)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_en, m_mode, m_pend, m_isr;
    logic [N-1:0] m_samp[$];
    int           m_state, m_id;
    logic         m_intr;
    logic [31:0]  m_rdata;

    function automatic int lowest_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] b;
        b = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_en = '0; m_mode = '0; m_pend = '0; m_isr = '0;
        m_state = M_IDLE; m_id = 0; m_intr = 1'b0; m_rdata = '0;
        m_samp.delete();
        for (int i = 0; i <= SYNC; i++) m_samp.push_back('0);
    endtask

    task automatic model_step();
        logic [N-1:0] s, sd, rise, pend_eff, req, clr, w1c, n_isr;
        int win, n_state, n_id;
        logic n_intr, wr, rd, eoi;
        s        = m_samp[SYNC-1];
        sd       = m_samp[SYNC];
        rise     = s & ~sd;
        pend_eff = (m_mode & m_pend) | (~m_mode & s);
        req      = pend_eff & m_en;
        win      = lowest_idx(req);
        wr       = io_cs && io_wr;
        rd       = io_cs && io_rd;
        eoi      = wr && io_addr == 3'd4;
        if (rd) begin
            case (io_addr)
                3'd0: m_rdata = 32'(m_en);
                3'd1: m_rdata = 32'(pend_eff);
                3'd2: m_rdata = 32'(m_mode);
                3'd3: m_rdata = ((m_isr != 0) ? 32'h8000_0000 : 32'h0) | 32'(m_id);
                default: m_rdata = 32'h0;
            endcase
        end
        n_state = m_state; n_id = m_id; n_intr = m_intr; n_isr = m_isr; clr = '0;
        if (m_state == M_IDLE) begin
            if (win >= 0) begin n_id = win; n_intr = 1'b1; n_state = M_ASSERT; end
        end else if (m_state == M_ASSERT) begin
            if (int_ack) begin
                n_intr = 1'b0; n_isr = m_isr | bit_of(m_id); clr = bit_of(m_id); n_state = M_SERVICE;
            end else if (!req[m_id]) begin
                n_intr = 1'b0;
`ifdef INTR_NEST_EN
                if (m_isr != 0) begin n_state = M_SERVICE; n_id = lowest_idx(m_isr); end
                else begin n_state = M_IDLE; n_id = 0; end
`else
                n_state = M_IDLE; n_id = 0;
`endif
            end else if (win < m_id) begin
                n_id = win;
            end
        end else begin
`ifdef INTR_NEST_EN
            if (eoi) begin
                n_isr = m_isr & ~bit_of(lowest_idx(m_isr));
                if (n_isr == 0) begin n_state = M_IDLE; n_id = 0; end
                else n_id = lowest_idx(n_isr);
            end else if (win >= 0 && win < lowest_idx(m_isr)) begin
                n_id = win; n_intr = 1'b1; n_state = M_ASSERT;
            end
`else
            if (eoi) begin n_isr = '0; n_state = M_IDLE; n_id = 0; end
`endif
        end
        w1c    = (wr && io_addr == 3'd1) ? io_wdata[N-1:0] : '0;
        m_pend = m_mode & (rise | (m_pend & ~(w1c | clr)));
        if (wr && io_addr == 3'd0) m_en   = io_wdata[N-1:0];
        if (wr && io_addr == 3'd2) m_mode = io_wdata[N-1:0];
        m_state = n_state; m_id = n_id; m_intr = n_intr; m_isr = n_isr;
        m_samp.push_front(irq_in);
        void'(m_samp.pop_back());
    endtask

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
        check("intr", 32'(intr), 32'(m_intr));
        check("irq_id", 32'(irq_id), 32'(m_id));
        check("io_rdata", io_rdata, m_rdata);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic io_write(input logic [2:0] addr, input logic [31:0] data);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = addr; io_wdata = data;
        step();
        io_cs = 1'b0; io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [2:0] addr, output logic [31:0] data);
        io_cs = 1'b1; io_rd = 1'b1; io_addr = addr;
        step();
        io_cs = 1'b0; io_rd = 1'b0;
        data = io_rdata;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic wait_intr(input string tag, input int budget);
        for (int i = 0; i < budget && intr !== 1'b1; i++) step();
        check(tag, 32'(intr), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        #3 reset = 1'b0;
        @(posedge sys_clk); @(posedge sys_clk); #1;
        reset = 1'b1;
        check("rst_intr", 32'(intr), 32'h0);
        check("rst_irq_id", 32'(irq_id), 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        io_read(3'd0, rd);  check("rst_enable", rd, 32'h0);

        // Level channel 3: latency, ack, ID, EOI, re-assert.
        io_write(3'd0, 32'hFF);
        io_write(3'd2, 32'h00);
        irq_in[3] = 1'b1;
        steps(2);           check("lvl_not_yet", 32'(intr), 32'h0);
        step();             check("lvl_latency", 32'(intr), 32'h1);
        check("lvl_id", 32'(irq_id), 32'd3);
        ack();              check("ack_drops_intr", 32'(intr), 32'h0);
        io_read(3'd3, rd);  check("id_in_service", rd, 32'h8000_0003);
        io_write(3'd4, 32'h0);
        io_read(3'd3, rd);  check("id_after_eoi", rd, 32'h0);
        check("lvl_reassert", 32'(intr), 32'h1);
        irq_in[3] = 1'b0;
        steps(4);           check("lvl_withdrawn", 32'(intr), 32'h0);

        // Edge channel 5: pending, ack clear, pulse held during SERVICE.
        io_write(3'd2, 32'hFF);
        irq_in[5] = 1'b1; step(); irq_in[5] = 1'b0;
        steps(3);           check("edge_latency", 32'(intr), 32'h1);
        io_read(3'd1, rd);  check("edge_pending", rd, 32'h20);
        ack();
        io_read(3'd1, rd);  check("edge_ack_clear", rd, 32'h0);
        irq_in[5] = 1'b1; step(); irq_in[5] = 1'b0;
        steps(4);
        io_read(3'd1, rd);  check("edge_held", rd, 32'h20);
        check("service_silent", 32'(intr), 32'h0);
        io_write(3'd4, 32'h0);
        wait_intr("edge_after_eoi", 8);
        ack(); io_write(3'd4, 32'h0);

        // Priority: channels 6 and 1 together.
        irq_in[6] = 1'b1; irq_in[1] = 1'b1; step(); irq_in[6] = 1'b0; irq_in[1] = 1'b0;
        wait_intr("prio_first", 8);
        check("prio_id1", 32'(irq_id), 32'd1);
        ack(); io_write(3'd4, 32'h0);
        wait_intr("prio_second", 8);
        check("prio_id6", 32'(irq_id), 32'd6);
        ack(); io_write(3'd4, 32'h0);

        // Level request withdrawn before ack.
        io_write(3'd2, 32'h00);
        irq_in[2] = 1'b1;
        wait_intr("withdraw_raise", 8);
        check("withdraw_id", 32'(irq_id), 32'd2);
        irq_in[2] = 1'b0;
        steps(4);           check("withdraw_intr", 32'(intr), 32'h0);
        io_read(3'd3, rd);  check("withdraw_no_isr", rd, 32'h0);

        // Rise in the same cycle as W1C of that bit.
        io_write(3'd0, 32'h00);
        io_write(3'd2, 32'hFF);
        irq_in[7] = 1'b1; step(); irq_in[7] = 1'b0; step();
        io_write(3'd1, 32'h80);
        io_read(3'd1, rd);  check("set_wins", rd, 32'h80);
        io_write(3'd1, 32'h80);
        io_read(3'd1, rd);  check("w1c_clears", rd, 32'h0);

        // Nesting: channel 0 raised while channel 4 is in service.
        io_write(3'd2, 32'h00);
        io_write(3'd0, 32'hFF);
        irq_in[4] = 1'b1;
        wait_intr("nest_ch4", 8);
        check("nest_id4", 32'(irq_id), 32'd4);
        ack();
        irq_in[0] = 1'b1;
        steps(5);
`ifdef INTR_NEST_EN
        check("nest_preempt", 32'(intr), 32'h1);
        check("nest_id0", 32'(irq_id), 32'd0);
        ack();
        irq_in[0] = 1'b0;
        io_read(3'd3, rd);  check("nest_id_inner", rd, 32'h8000_0000);
        steps(3);
        io_write(3'd4, 32'h0);
        io_read(3'd3, rd);  check("nest_back_to_4", rd, 32'h8000_0004);
        check("nest_still_service", 32'(intr), 32'h0);
        io_write(3'd4, 32'h0);
        io_read(3'd3, rd);  check("nest_idle", rd, 32'h0);
`else
        check("nonest_silent", 32'(intr), 32'h0);
        io_read(3'd3, rd);  check("nonest_id", rd, 32'h8000_0004);
        io_write(3'd4, 32'h0);
        wait_intr("nonest_after_eoi", 8);
        check("nonest_id0", 32'(irq_id), 32'd0);
        ack(); io_write(3'd4, 32'h0);
`endif
        irq_in = '0;
        steps(6);           check("nest_quiet", 32'(intr), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            int op;
            if ($urandom_range(0, 7) == 0) irq_in[$urandom_range(0, N-1)] ^= 1'b1;
            op = $urandom_range(0, 11);
            io_addr  = 3'($urandom_range(0, 7));
            io_wdata = $urandom | $urandom;
            case (op)
                0, 1: begin io_cs = 1'b1; io_rd = 1'b1; end
                2: begin io_cs = 1'b1; io_wr = 1'b1; io_addr = 3'd0; end
                3: begin io_cs = 1'b1; io_wr = 1'b1; io_addr = 3'd2; end
                4: begin io_cs = 1'b1; io_wr = 1'b1; io_addr = 3'd1; io_wdata = $urandom; end
                5: begin io_cs = 1'b1; io_wr = 1'b1; io_addr = 3'd4; end
                6: begin io_cs = 1'b0; io_wr = 1'b1; end
                default: ;
            endcase
            int_ack = (intr && $urandom_range(0, 3) == 0) || ($urandom_range(0, 31) == 0);
            step();
            io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; int_ack = 1'b0;
        end

        // Asynchronous reset while in service.
        irq_in = '0;
        steps(6);
        io_write(3'd2, 32'h00);
        io_write(3'd0, 32'hFF);
        io_write(3'd4, 32'h0);
        steps(6);
        irq_in[1] = 1'b1;
        wait_intr("rst_setup", 12);
        ack();
        io_read(3'd3, rd);  check("rst_setup_id", rd, 32'h8000_0001);
        #3 reset = 1'b0;
        #1;
        check("async_rst_intr", 32'(intr), 32'h0);
        check("async_rst_irq_id", 32'(irq_id), 32'h0);
        check("async_rst_rdata", io_rdata, 32'h0);
        irq_in = '0;
        steps(2);
        reset = 1'b1;
        io_read(3'd0, rd);  check("async_rst_enable", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
